// File: rtl/data_memory_pkg.sv
// Shared types and constants for the handshaked data memory.
package data_memory_pkg;

  // Controller states: array clear after reset, idle, latency wait, response hold.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Largest supported access latency; the wait counter is sized to hold it.
  localparam int LATENCY_MAX = 15;
  localparam int WCNT_W      = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read on one address.
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; contents are not reset here, the controller clears them word by word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/data_memory_hs.sv
// Handshaked data memory for the MEM stage: clears itself after reset, then serves
// one request at a time with a configurable wait before the response.
module data_memory_hs
  import data_memory_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              init_done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_W:0]     DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]    LAST_IDX  = CNT_W'(DEPTH - 1);
  localparam logic [WCNT_W-1:0]   LAT_INIT  = WCNT_W'(LATENCY);

  state_e state_q, state_d;

  logic [CNT_W-1:0]  clrCnt_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              respValid_q;
  logic              respErr_q;
  logic [DATA_W-1:0] respRdata_q;
  logic              initDone_q;

  logic              accept;
  logic              doAccess;
  logic              curWe;
  logic [ADDR_W-1:0] curAddr;
  logic [DATA_W-1:0] curWdata;
  logic              inRange;
  logic              arrayWe;
  logic [IDX_W-1:0]  arrayAddr;
  logic [DATA_W-1:0] arrayWdata;
  logic [DATA_W-1:0] arrayRdata;

  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign doAccess = (accept && (LATENCY == 0)) ||
                    ((state_q == ST_WAIT) && (wcnt_q == WCNT_W'(1)));

  // Pick the request being served: live inputs for a zero-latency access, latched copy otherwise.
  always_comb begin
    curWe    = we_q;
    curAddr  = addr_q;
    curWdata = wdata_q;
    if (state_q == ST_IDLE && req_valid) begin
      curWe    = req_we;
      curAddr  = req_addr;
      curWdata = req_wdata;
    end
    inRange = ({1'b0, curAddr} < DEPTH_EXT);
  end

  // State register; reset always restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for clear, accept, latency countdown and response handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR: if (clrCnt_q == LAST_IDX) state_d = ST_IDLE;
      ST_IDLE:  if (accept) state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (wcnt_q == WCNT_W'(1)) state_d = ST_RESP;
      ST_RESP:  if (resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Outputs and array port: clear writes zeros, committed writes only when in range and not in reset.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    arrayWe    = 1'b0;
    arrayAddr  = inRange ? curAddr[IDX_W-1:0] : '0;
    arrayWdata = curWdata;
    if (state_q == ST_CLEAR) begin
      arrayAddr  = clrCnt_q[IDX_W-1:0];
      arrayWdata = '0;
      arrayWe    = !rst;
    end else if (doAccess && curWe && inRange && !rst) begin
      arrayWe = 1'b1;
    end
  end

  // Counters, request latch and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      clrCnt_q    <= '0;
      wcnt_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      respValid_q <= 1'b0;
      respErr_q   <= 1'b0;
      respRdata_q <= '0;
      initDone_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          clrCnt_q <= clrCnt_q + CNT_W'(1);
          if (clrCnt_q == LAST_IDX) initDone_q <= 1'b1;
        end
        ST_IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wcnt_q  <= LAT_INIT;
          end
        end
        ST_WAIT: begin
          wcnt_q <= wcnt_q - WCNT_W'(1);
        end
        ST_RESP: begin
          if (resp_ready) begin
            respValid_q <= 1'b0;
            respErr_q   <= 1'b0;
          end
        end
        default: ;
      endcase
      if (doAccess) begin
        respValid_q <= 1'b1;
        respErr_q   <= !inRange;
        respRdata_q <= (inRange && !curWe) ? arrayRdata : '0;
      end
    end
  end

  dmem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) uArray (
    .clk    (clk),
    .we_i   (arrayWe),
    .addr_i (arrayAddr),
    .wdata_i(arrayWdata),
    .rdata_o(arrayRdata)
  );

  assign resp_valid = respValid_q;
  assign resp_err   = respErr_q;
  assign resp_rdata = respRdata_q;
  assign init_done  = initDone_q;

endmodule

// File: tb/tb_data_memory_hs.sv
// Directed bench for data_memory_hs: three instances (latency 0, 3, 5), depth 256.
module tb_data_memory_hs;

   localparam int N = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst       [N];
   logic        reqValid  [N];
   logic        reqReady  [N];
   logic        reqWe     [N];
   logic [15:0] reqAddr   [N];
   logic [15:0] reqWdata  [N];
   logic        respValid [N];
   logic        respReady [N];
   logic [15:0] respRdata [N];
   logic        respErr   [N];
   logic        initDone  [N];

   int errors = 0;
   int checks = 0;

   for (genvar g = 0; g < N; g++) begin : gDut
      data_memory_hs #(
         .DATA_W (16),
         .ADDR_W (16),
         .DEPTH  (256),
         .LATENCY((g == 0) ? 0 : ((g == 1) ? 3 : 5))
      ) dut (
         .clk       (clk),
         .rst       (rst[g]),
         .req_valid (reqValid[g]),
         .req_ready (reqReady[g]),
         .req_we    (reqWe[g]),
         .req_addr  (reqAddr[g]),
         .req_wdata (reqWdata[g]),
         .resp_valid(respValid[g]),
         .resp_ready(respReady[g]),
         .resp_rdata(respRdata[g]),
         .resp_err  (respErr[g]),
         .init_done (initDone[g])
      );
   end

   // Expected latency of each instance, matching the parameters above.
   function automatic int latOf(input int idx);
      case (idx)
         0:       return 0;
         1:       return 3;
         default: return 5;
      endcase
   endfunction

   // Advance to just after the next rising edge, where outputs are settled.
   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   // Count one comparison and report it if the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Present one request and return just after the edge that accepts it.
   task automatic applyStimulus(input int idx, input logic we, input logic [15:0] addr,
                                input logic [15:0] wdata, input string tag);
      int guard = 0;
      while (reqReady[idx] !== 1'b1 && guard < 20) begin
         stepClk();
         guard++;
      end
      checkOutput({tag, "_ready"}, 32'(reqReady[idx]), 32'd1);
      reqValid[idx] = 1'b1;
      reqWe[idx]    = we;
      reqAddr[idx]  = addr;
      reqWdata[idx] = wdata;
      stepClk();
      reqValid[idx] = 1'b0;
      reqWe[idx]    = 1'b0;
      reqAddr[idx]  = 16'h0000;
      reqWdata[idx] = 16'h0000;
   endtask

   // Wait (bounded) for the response, counting cycles and noting any req_ready while busy.
   task automatic waitResp(input int idx, output int cycles, output logic leak);
      cycles = 0;
      leak   = 1'b0;
      while (respValid[idx] !== 1'b1 && cycles < 40) begin
         if (reqReady[idx] !== 1'b0) leak = 1'b1;
         stepClk();
         cycles++;
      end
      if (reqReady[idx] !== 1'b0) leak = 1'b1;
   endtask

   task automatic takeResp(input int idx);
      respReady[idx] = 1'b1;
      stepClk();
      respReady[idx] = 1'b0;
   endtask

   // One complete transaction with checks on latency, busy flag, data, error and release.
   task automatic doAccess(input int idx, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] expRdata,
                           input logic expErr, input string tag);
      int   cycles;
      logic leak;
      applyStimulus(idx, we, addr, wdata, tag);
      waitResp(idx, cycles, leak);
      checkOutput({tag, "_valid"}, 32'(respValid[idx]), 32'd1);
      checkOutput({tag, "_lat"},   32'(cycles), 32'(latOf(idx)));
      checkOutput({tag, "_busy"},  32'(leak), 32'd0);
      checkOutput({tag, "_rdata"}, 32'(respRdata[idx]), 32'(expRdata));
      checkOutput({tag, "_err"},   32'(respErr[idx]), 32'(expErr));
      takeResp(idx);
      checkOutput({tag, "_drop"},  32'(respValid[idx]), 32'd0);
      checkOutput({tag, "_errclr"}, 32'(respErr[idx]), 32'd0);
   endtask

   // Hard stop in case something wedges the sequence.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   cyc;
      logic leak;
      logic stable;
      logic sawResp;

      for (int i = 0; i < N; i++) begin
         rst[i]       = 1'b1;
         reqValid[i]  = 1'b0;
         reqWe[i]     = 1'b0;
         reqAddr[i]   = 16'h0000;
         reqWdata[i]  = 16'h0000;
         respReady[i] = 1'b0;
      end

      // Reset pulse for one edge, then the clear sequence.
      stepClk();
      for (int i = 0; i < N; i++) rst[i] = 1'b0;
      checkOutput("rst_init_done",  32'(initDone[0]),  32'd0);
      checkOutput("rst_req_ready",  32'(reqReady[0]),  32'd0);
      checkOutput("rst_resp_valid", 32'(respValid[0]), 32'd0);
      checkOutput("rst_resp_err",   32'(respErr[0]),   32'd0);
      checkOutput("rst_resp_rdata", 32'(respRdata[0]), 32'd0);

      cyc  = 0;
      leak = 1'b0;
      while (initDone[0] !== 1'b1 && cyc < 400) begin
         if (reqReady[0] !== 1'b0) leak = 1'b1;
         stepClk();
         cyc++;
      end
      checkOutput("init_cycles",     32'(cyc), 32'd256);
      checkOutput("init_ready_leak", 32'(leak), 32'd0);
      checkOutput("init_ready_up",   32'(reqReady[0]), 32'd1);

      // Freshly cleared words read as zero.
      doAccess(0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, "clr_rd0");
      doAccess(0, 1'b0, 16'h0080, 16'h0000, 16'h0000, 1'b0, "clr_rd128");
      doAccess(0, 1'b0, 16'h00FF, 16'h0000, 16'h0000, 1'b0, "clr_rd255");

      // Zero-latency write then read-back.
      doAccess(0, 1'b1, 16'h0012, 16'hBEEF, 16'h0000, 1'b0, "l0_wr");
      doAccess(0, 1'b0, 16'h0012, 16'h0000, 16'hBEEF, 1'b0, "l0_rd");

      // Out-of-range write flags an error and must not alias onto word 0.
      doAccess(0, 1'b1, 16'h0100, 16'h1234, 16'h0000, 1'b1, "oor_wr");
      doAccess(0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, "oor_alias");
      doAccess(0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, "oor_rd");

      // Latency 3: timing, busy window and write ordering.
      doAccess(1, 1'b0, 16'h0012, 16'h0000, 16'h0000, 1'b0, "l3_rd0");
      doAccess(1, 1'b1, 16'h0034, 16'h5A5A, 16'h0000, 1'b0, "l3_wr");
      doAccess(1, 1'b0, 16'h0034, 16'h0000, 16'h5A5A, 1'b0, "l3_rd");

      // Backpressure: response held for 5 cycles while a competing write is offered.
      applyStimulus(1, 1'b0, 16'h0034, 16'h0000, "bp_rd");
      waitResp(1, cyc, leak);
      checkOutput("bp_valid", 32'(respValid[1]), 32'd1);
      checkOutput("bp_rdata", 32'(respRdata[1]), 32'h5A5A);
      reqValid[1] = 1'b1;
      reqWe[1]    = 1'b1;
      reqAddr[1]  = 16'h0034;
      reqWdata[1] = 16'hDEAD;
      stable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         stepClk();
         if (respValid[1] !== 1'b1 || respRdata[1] !== 16'h5A5A || reqReady[1] !== 1'b0) stable = 1'b0;
      end
      checkOutput("bp_stable", 32'(stable), 32'd1);
      reqValid[1] = 1'b0;
      reqWe[1]    = 1'b0;
      takeResp(1);
      checkOutput("bp_idle_ready", 32'(reqReady[1]), 32'd1);
      checkOutput("bp_drop",       32'(respValid[1]), 32'd0);
      checkOutput("bp_rdata_keep", 32'(respRdata[1]), 32'h5A5A);
      doAccess(1, 1'b0, 16'h0034, 16'h0000, 16'h5A5A, 1'b0, "bp_after");

      // Latency 5: normal traffic, then a reset during the second wait cycle.
      doAccess(2, 1'b1, 16'h0007, 16'h1111, 16'h0000, 1'b0, "l5_wr");
      doAccess(2, 1'b0, 16'h0007, 16'h0000, 16'h1111, 1'b0, "l5_rd");
      applyStimulus(2, 1'b1, 16'h0007, 16'hAAAA, "rw_wr");
      stepClk();
      rst[2] = 1'b1;
      stepClk();
      rst[2] = 1'b0;
      checkOutput("rw_valid_rst", 32'(respValid[2]), 32'd0);
      checkOutput("rw_init_rst",  32'(initDone[2]),  32'd0);
      cyc     = 0;
      sawResp = 1'b0;
      while (initDone[2] !== 1'b1 && cyc < 400) begin
         if (respValid[2] !== 1'b0) sawResp = 1'b1;
         stepClk();
         cyc++;
      end
      checkOutput("rw_no_resp",     32'(sawResp), 32'd0);
      checkOutput("rw_init_cycles", 32'(cyc), 32'd256);
      doAccess(2, 1'b0, 16'h0007, 16'h0000, 16'h0000, 1'b0, "rw_rd");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
